// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int REQ_ADDR_W = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Error code: unaligned byte address or bits above the decoded range set
    function automatic logic addr_illegal(input logic [REQ_ADDR_W-1:0] addr, input int addr_w);
        logic [REQ_ADDR_W-1:0] hi;
        hi = addr >> addr_w;
        return addr[0] | (hi != '0);
    endfunction
endpackage

// File: rtl/mem_array_sp.sv
// rtl/mem_array_sp.sv - single-port word array, synchronous write, asynchronous read
module mem_array_sp
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-cycle load/store responder with fixed latency and address checks
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int IDX_W = ADDR_W - 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               wr_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  arr_rdata;
    logic               arr_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt       <= CNT_LOAD;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_ONE) begin
                        state     <= RESP;
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Request register is data only; the legality check is folded in at capture time
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            wr_q    <= req_wr;
            err_q   <= addr_illegal(req_addr, ADDR_W);
            idx_q   <= req_addr[ADDR_W-1:1];
            wdata_q <= req_wdata;
        end
    end

    assign arr_we    = (state == RESP) & wr_q & ~err_q;
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid & ~wr_q & ~err_q) ? arr_rdata : '0;

    mem_array_sp #(
        .DEPTH (DEPTH),
        .AW    (IDX_W),
        .DW    (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );
endmodule
